// File: rtl/dt_tree_walker_if.sv
// ---------------------------------------------------------------------------
// dt_tree_walker_if
//   Bus bundle for dt_tree_walker: node-memory write port, request
//   handshake carrying the tree select and feature vector, and the
//   result handshake carrying class, abort flag and visit count.
//
//   master : the side that loads nodes, issues requests, accepts results
//   slave  : the tree walker itself
//
//   Signals
//     wr_en / wr_addr {tree,node} / wr_data   node write, honoured in IDLE only
//     wr_drop                                 pulse: a write was discarded
//     in_valid / in_ready / in_tree / in_features   request handshake
//     out_valid / out_ready / out_class / out_err / out_depth   result handshake
// ---------------------------------------------------------------------------
interface dt_tree_walker_if #(
    parameter int NUM_TREES       = 8,
    parameter int NODE_ADDR_WIDTH = 9,
    parameter int NUM_FEATURES    = 16,
    parameter int FEATURE_WIDTH   = 16,
    parameter int CLASS_WIDTH     = 4
);
    localparam int TREE_W     = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
    localparam int FIDX_W     = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int NODE_WIDTH = 1 + FIDX_W + FEATURE_WIDTH + 2 * NODE_ADDR_WIDTH;

    logic                                    wr_en;
    logic [TREE_W+NODE_ADDR_WIDTH-1:0]       wr_addr;
    logic [NODE_WIDTH-1:0]                   wr_data;
    logic                                    wr_drop;
    logic                                    in_valid;
    logic                                    in_ready;
    logic [TREE_W-1:0]                       in_tree;
    logic [NUM_FEATURES*FEATURE_WIDTH-1:0]   in_features;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [CLASS_WIDTH-1:0]                  out_class;
    logic                                    out_err;
    logic [7:0]                              out_depth;

    modport master (
        output wr_en, wr_addr, wr_data, in_valid, in_tree, in_features, out_ready,
        input  wr_drop, in_ready, out_valid, out_class, out_err, out_depth
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, in_valid, in_tree, in_features, out_ready,
        output wr_drop, in_ready, out_valid, out_class, out_err, out_depth
    );
endinterface

// File: rtl/dt_tree_walker.sv
// ---------------------------------------------------------------------------
// dt_tree_walker
//   Multi-tree decision-tree inference engine. NUM_TREES trees live in a
//   writable node memory (synchronous 1-cycle read). Each accepted request
//   walks one tree from node 0 against the captured feature vector and
//   returns the leaf class.
//
//   Node word, MSB..LSB: is_leaf | feat_idx | threshold | left | right.
//   A leaf's class is the low CLASS_WIDTH bits of its word.
//
//   Ports
//     clk  : clock
//     rst  : synchronous, active-high reset (aborts any walk, keeps memory)
//     bus  : dt_tree_walker_if.slave (write port, request, result)
//
//   Optional feature: define DT_DEPTH_GUARD_EN to abort a walk that reaches
//   a non-leaf node after MAX_DEPTH visits (out_err=1, out_class=0).
//   Without it out_err is always 0 and a cyclic tree never finishes.
//
//   Latency accept -> out_valid is 2*D+1 cycles for D nodes visited.
// ---------------------------------------------------------------------------
module dt_tree_walker #(
    parameter int NUM_TREES       = 8,
    parameter int NODE_ADDR_WIDTH = 9,
    parameter int NUM_FEATURES    = 16,
    parameter int FEATURE_WIDTH   = 16,
    parameter int CLASS_WIDTH     = 4,
    parameter int MAX_DEPTH       = 32
) (
    input  logic            clk,
    input  logic            rst,
    dt_tree_walker_if.slave bus
);
    localparam int TREE_W     = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
    localparam int FIDX_W     = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int NODE_WIDTH = 1 + FIDX_W + FEATURE_WIDTH + 2 * NODE_ADDR_WIDTH;
    localparam int MEM_DEPTH  = NUM_TREES << NODE_ADDR_WIDTH;
    localparam int FV_W       = NUM_FEATURES * FEATURE_WIDTH;

    // The depth counter is 8 bits wide, so the limit must fit in it.
    if (MAX_DEPTH < 1 || MAX_DEPTH > 255) begin : g_max_depth_check
        $error("dt_tree_walker: MAX_DEPTH must lie in 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EVAL, S_DONE} state_t;

    state_t                       r_state;
    logic [TREE_W-1:0]            r_tree;
    logic [NODE_ADDR_WIDTH-1:0]   r_node;
    logic [FV_W-1:0]              r_features;
    logic [7:0]                   r_depth;
    logic [NODE_WIDTH-1:0]        r_mem [MEM_DEPTH];
    logic [NODE_WIDTH-1:0]        r_rd_data;
    logic                         r_out_valid;
    logic [CLASS_WIDTH-1:0]       r_out_class;
    logic                         r_out_err;
    logic [7:0]                   r_out_depth;
    logic                         r_wr_drop;

    logic                         w_wr_commit;
    logic                         w_is_leaf;
    logic [FIDX_W-1:0]            w_fidx;
    logic [FEATURE_WIDTH-1:0]     w_thresh;
    logic [NODE_ADDR_WIDTH-1:0]   w_left;
    logic [NODE_ADDR_WIDTH-1:0]   w_right;
    logic [FEATURE_WIDTH-1:0]     w_feat;
    logic                         w_take_left;

    // Writes only land while no walk is in flight, so a walk always sees a
    // consistent tree. A write in the accept cycle lands before the first read.
    assign w_wr_commit = bus.wr_en && (r_state == S_IDLE) && !rst;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking '=' here would create order-dependent races.
    // NOTE: the node memory is deliberately not reset -- clearing thousands
    // of words is not possible in one cycle and contents must survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
        // Address is valid during FETCH; the word is consumed in EVAL.
        r_rd_data <= r_mem[{r_tree, r_node}];
    end

    // Node word fields.
    assign w_is_leaf = r_rd_data[NODE_WIDTH-1];
    assign w_fidx    = r_rd_data[NODE_WIDTH-2 -: FIDX_W];
    assign w_thresh  = r_rd_data[2*NODE_ADDR_WIDTH +: FEATURE_WIDTH];
    assign w_left    = r_rd_data[NODE_ADDR_WIDTH +: NODE_ADDR_WIDTH];
    assign w_right   = r_rd_data[0 +: NODE_ADDR_WIDTH];

    // Feature mux; an index beyond NUM_FEATURES selects the value 0.
    // NOTE: the default assignment first keeps this purely combinational
    // (no latch) for index values that match no loop iteration.
    always_comb begin
        w_feat = '0;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            if (w_fidx == FIDX_W'(i)) begin
                w_feat = r_features[i*FEATURE_WIDTH +: FEATURE_WIDTH];
            end
        end
    end

    assign w_take_left = ($signed(w_feat) <= $signed(w_thresh));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tree      <= '0;
            r_node      <= '0;
            r_features  <= '0;
            r_depth     <= '0;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_err   <= 1'b0;
            r_out_depth <= '0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_wr_drop <= bus.wr_en && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_tree     <= bus.in_tree;
                        r_features <= bus.in_features;
                        r_node     <= '0;
                        r_depth    <= '0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_depth != 8'hFF) begin
                        r_depth <= r_depth + 8'd1;
                    end
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    if (w_is_leaf) begin
                        r_out_class <= r_rd_data[CLASS_WIDTH-1:0];
                        r_out_err   <= 1'b0;
                        r_out_depth <= r_depth;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
`ifdef DT_DEPTH_GUARD_EN
                    end else if (r_depth == 8'(MAX_DEPTH)) begin
                        r_out_class <= '0;
                        r_out_err   <= 1'b1;
                        r_out_depth <= r_depth;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
`endif
                    end else begin
                        // Child index wraps naturally inside the node field.
                        r_node  <= w_take_left ? w_left : w_right;
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // in_ready is decoded from the state so it is already high in the first
    // cycle after reset releases, and low while rst is held.
    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.out_class = r_out_class;
    assign bus.out_err   = r_out_err;
    assign bus.out_depth = r_out_depth;
    assign bus.wr_drop   = r_wr_drop;
endmodule

// File: tb/tb_dt_tree_walker.sv
`timescale 1ns/1ps
module tb_dt_tree_walker;
    localparam int NT = 8, NAW = 9, NF = 16, FW = 16, CW = 4, MD = 4;
    localparam int TREE_W = 3, FIDX_W = 4;
    localparam int NODE_WIDTH = 1 + FIDX_W + FW + 2 * NAW;
    localparam int FV_W = NF * FW;
    localparam int BUDGET = 2000;
`ifdef DT_DEPTH_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef logic [NODE_WIDTH-1:0] word_t;
    typedef logic [FV_W-1:0] fvec_t;

    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_fail = 0;
    word_t mdl_mem [NT][1<<NAW];

    dt_tree_walker_if #(.NUM_TREES(NT), .NODE_ADDR_WIDTH(NAW), .NUM_FEATURES(NF),
                        .FEATURE_WIDTH(FW), .CLASS_WIDTH(CW)) bus ();

    dt_tree_walker #(.NUM_TREES(NT), .NODE_ADDR_WIDTH(NAW), .NUM_FEATURES(NF),
                     .FEATURE_WIDTH(FW), .CLASS_WIDTH(CW), .MAX_DEPTH(MD)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic word_t mk_leaf(input int cls);
        word_t w;
        w = '0;
        w[NODE_WIDTH-1] = 1'b1;
        w[CW-1:0] = CW'(cls);
        return w;
    endfunction

    function automatic word_t mk_node(input int fidx, input int thr, input int left, input int right);
        return {1'b0, FIDX_W'(fidx), FW'(thr), NAW'(left), NAW'(right)};
    endfunction

    function automatic fvec_t rand_feats();
        fvec_t f;
        for (int i = 0; i < NF; i++) begin
            if ($urandom_range(0, 3) == 0) f[i*FW +: FW] = FW'($urandom);
            else f[i*FW +: FW] = FW'(int'($urandom_range(0, 12)) - 6);
        end
        return f;
    endfunction

    // Reference walk: follow the stored tree from node 0 with integer compares.
    function automatic void model_walk(input int tree, input fvec_t f,
                                       output int cls, output int depth, output bit err);
        int node, fidx, thr, fv;
        word_t w;
        node = 0; cls = 0; depth = 0; err = 1'b0;
        for (int step = 0; step < 1000; step++) begin
            w = mdl_mem[tree][node];
            depth++;
            if (w[NODE_WIDTH-1]) begin
                cls = int'(w[CW-1:0]);
                return;
            end
            if (GUARD && depth == MD) begin
                err = 1'b1;
                return;
            end
            fidx = int'(w[NODE_WIDTH-2 -: FIDX_W]);
            thr  = int'($signed(w[2*NAW +: FW]));
            fv   = (fidx < NF) ? int'($signed(f[fidx*FW +: FW])) : 0;
            node = (fv <= thr) ? int'(w[NAW +: NAW]) : int'(w[0 +: NAW]);
        end
        err = 1'b1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic write_node(input int tree, input int node, input word_t w);
        bus.wr_en = 1'b1;
        bus.wr_addr = {TREE_W'(tree), NAW'(node)};
        bus.wr_data = w;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        mdl_mem[tree][node] = w;
    endtask

    // Issue one request and check the result fields and latency. Returns in
    // IDLE when out_ready is high, otherwise still holding the DONE result.
    task automatic do_walk(input int tree, input fvec_t f, input string name,
                           input int exp_cls, input int exp_depth, input bit exp_err);
        int w, lat;
        bit got;
        w = 0;
        while (!bus.in_ready && w < BUDGET) begin
            @(posedge clk); #1; w++;
        end
        bus.in_valid = 1'b1;
        bus.in_tree = TREE_W'(tree);
        bus.in_features = f;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        got = 1'b0; lat = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            if (bus.out_valid) begin
                lat = c; got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s.timeout: no out_valid within %0d cycles", name, BUDGET);
            apply_reset();
            return;
        end
        n_cmp++;
        if (bus.out_class !== CW'(exp_cls)) begin
            n_fail++; $display("FAIL %s.class: got %0d expected %0d", name, bus.out_class, exp_cls);
        end
        n_cmp++;
        if (bus.out_depth !== 8'(exp_depth)) begin
            n_fail++; $display("FAIL %s.depth: got %0d expected %0d", name, bus.out_depth, exp_depth);
        end
        n_cmp++;
        if (bus.out_err !== exp_err) begin
            n_fail++; $display("FAIL %s.err: got %0b expected %0b", name, bus.out_err, exp_err);
        end
        n_cmp++;
        if (lat != 2 * exp_depth + 1) begin
            n_fail++; $display("FAIL %s.latency: got %0d expected %0d", name, lat, 2 * exp_depth + 1);
        end
        if (bus.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst.in_ready: got %0b expected 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst.out_valid: got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_class !== '0) begin n_fail++; $display("FAIL rst.out_class: got %0d expected 0", bus.out_class); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL rst.out_err: got %0b expected 0", bus.out_err); end
        n_cmp++; if (bus.out_depth !== 8'd0) begin n_fail++; $display("FAIL rst.out_depth: got %0d expected 0", bus.out_depth); end
        n_cmp++; if (bus.wr_drop !== 1'b0) begin n_fail++; $display("FAIL rst.wr_drop: got %0b expected 0", bus.wr_drop); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst.ready_after: got %0b expected 1", bus.in_ready); end
    endtask

    task automatic test_root_leaf();
        write_node(0, 0, mk_leaf(5));
        do_walk(0, rand_feats(), "root_leaf", 5, 1, 1'b0);
    endtask

    task automatic test_three_level();
        fvec_t f;
        write_node(3, 0, mk_node(2, -4, 1, 2));
        write_node(3, 1, mk_leaf(1));
        write_node(3, 2, mk_leaf(2));
        f = rand_feats();
        f[2*FW +: FW] = FW'(-4);     do_walk(3, f, "tl_equal", 1, 2, 1'b0);
        f[2*FW +: FW] = FW'(-3);     do_walk(3, f, "tl_above", 2, 2, 1'b0);
        f[2*FW +: FW] = 16'h8000;    do_walk(3, f, "tl_min", 1, 2, 1'b0);
        f[2*FW +: FW] = 16'h7FFF;    do_walk(3, f, "tl_max", 2, 2, 1'b0);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        do_walk(0, rand_feats(), "bp_first", 5, 1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp.hold_valid[%0d]: got %0b expected 1", c, bus.out_valid); end
            n_cmp++; if (bus.out_class !== 4'd5) begin n_fail++; $display("FAIL bp.hold_class[%0d]: got %0d expected 5", c, bus.out_class); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp.in_ready[%0d]: got %0b expected 0", c, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp.release_valid: got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp.release_idle: got %0b expected 1", bus.in_ready); end
    endtask

    task automatic test_write_during_walk();
        write_node(1, 0, mk_node(0, 0, 1, 1));
        write_node(1, 1, mk_leaf(7));
        bus.in_valid = 1'b1; bus.in_tree = TREE_W'(1); bus.in_features = rand_feats();
        @(posedge clk); #1;                       // FETCH
        bus.in_valid = 1'b0;
        @(posedge clk); #1;                       // EVAL
        bus.wr_en = 1'b1; bus.wr_addr = {TREE_W'(1), NAW'(1)}; bus.wr_data = mk_leaf(9);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.wr_drop !== 1'b1) begin n_fail++; $display("FAIL wdw.drop_pulse: got %0b expected 1", bus.wr_drop); end
        @(posedge clk); #1;
        n_cmp++; if (bus.wr_drop !== 1'b0) begin n_fail++; $display("FAIL wdw.drop_end: got %0b expected 0", bus.wr_drop); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL wdw.valid: got %0b expected 1", bus.out_valid); end
        n_cmp++; if (bus.out_class !== 4'd7) begin n_fail++; $display("FAIL wdw.class: got %0d expected 7", bus.out_class); end
        @(posedge clk); #1;
        do_walk(1, rand_feats(), "wdw_readback", 7, 2, 1'b0);
    endtask

    task automatic test_simul_write();
        write_node(2, 0, mk_leaf(3));
        bus.wr_en = 1'b1; bus.wr_addr = {TREE_W'(2), NAW'(0)}; bus.wr_data = mk_leaf(11);
        bus.in_valid = 1'b1; bus.in_tree = TREE_W'(2); bus.in_features = rand_feats();
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.in_valid = 1'b0;
        mdl_mem[2][0] = mk_leaf(11);
        n_cmp++; if (bus.wr_drop !== 1'b0) begin n_fail++; $display("FAIL sim.no_drop: got %0b expected 0", bus.wr_drop); end
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sim.valid: got %0b expected 1", bus.out_valid); end
        n_cmp++; if (bus.out_class !== 4'd11) begin n_fail++; $display("FAIL sim.class: got %0d expected 11", bus.out_class); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int w;
        bus.in_tree = TREE_W'(0); bus.in_features = rand_feats(); bus.in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (bus.in_ready) acc.push_back(c);
            if (bus.out_valid) begin
                n_cmp++; if (bus.out_class !== 4'd5) begin n_fail++; $display("FAIL b2b.class: got %0d expected 5", bus.out_class); end
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (acc.size() < 5) begin n_fail++; $display("FAIL b2b.accepts: got %0d expected >= 5", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            n_cmp++;
            if (acc[i] - acc[i-1] != 4) begin n_fail++; $display("FAIL b2b.period: got %0d expected 4", acc[i] - acc[i-1]); end
        end
        w = 0;
        while (!bus.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    endtask

    task automatic test_reset_mid_walk();
        fvec_t f;
        f = rand_feats();
        f[2*FW +: FW] = FW'(-4);
        bus.in_valid = 1'b1; bus.in_tree = TREE_W'(3); bus.in_features = f;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmw.valid: got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmw.in_ready: got %0b expected 0", bus.in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmw.idle: got %0b expected 1", bus.in_ready); end
        f[2*FW +: FW] = FW'(-3);
        do_walk(3, f, "rmw_after", 2, 2, 1'b0);
    endtask

    task automatic test_cyclic();
        write_node(4, 0, mk_node(0, 0, 0, 0));
`ifdef DT_DEPTH_GUARD_EN
        do_walk(4, rand_feats(), "guard", 0, MD, 1'b1);
`else
        begin
            int seen;
            seen = 0;
            bus.in_valid = 1'b1; bus.in_tree = TREE_W'(4); bus.in_features = rand_feats();
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (bus.out_valid) seen++;
                @(posedge clk); #1;
            end
            n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL cyc.no_result: got %0d expected 0", seen); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL cyc.busy: got %0b expected 0", bus.in_ready); end
            apply_reset();
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL cyc.recover: got %0b expected 1", bus.in_ready); end
        end
`endif
        do_walk(0, rand_feats(), "cyc_after", 5, 1, 1'b0);
    endtask

    task automatic test_random();
        localparam int K = 24;
        int t, cls, dep;
        bit err;
        fvec_t f;
        for (int tr = 5; tr < NT; tr++) begin
            for (int n = 0; n < K; n++) begin
                if (n >= K - 2 || $urandom_range(0, 3) == 0)
                    write_node(tr, n, mk_leaf(int'($urandom_range(0, 15))));
                else
                    write_node(tr, n, mk_node(int'($urandom_range(0, NF - 1)),
                                              int'($urandom_range(0, 10)) - 5,
                                              int'($urandom_range(n + 1, K - 1)),
                                              int'($urandom_range(n + 1, K - 1))));
            end
        end
        for (int k = 0; k < 40; k++) begin
            t = int'($urandom_range(0, 6));
            if (t >= 4) t++;
            f = rand_feats();
            model_walk(t, f, cls, dep, err);
            do_walk(t, f, $sformatf("rand%0d_t%0d", k, t), cls, dep, err);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.in_valid = 1'b0; bus.in_tree = '0; bus.in_features = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_root_leaf();
        test_three_level();
        test_backpressure();
        test_write_during_walk();
        test_simul_write();
        test_back_to_back();
        test_reset_mid_walk();
        test_cyclic();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dt_tree_walker.md
# dt_tree_walker

Parametrised decision-tree inference engine: holds `NUM_TREES` trees in a writable, synchronously read node memory and walks one selected tree per request against a captured feature vector, returning the leaf class. It is the run-time-loadable, multi-tree successor to the per-tree constant node ROMs. It sits between the feature-extraction front end and the ensemble voter.

## Interface
Parameters:
- `NUM_TREES`, 8: trees stored. `TREE_W = max(1, clog2(NUM_TREES))`.
- `NODE_ADDR_WIDTH`, 9: node index width per tree (512 nodes/tree).
- `NUM_FEATURES`, 16: features per vector. `FIDX_W = max(1, clog2(NUM_FEATURES))`.
- `FEATURE_WIDTH`, 16: signed two's-complement feature and threshold width.
- `CLASS_WIDTH`, 4: class label width.
- `MAX_DEPTH`, 32: node-visit limit; used only with `DT_DEPTH_GUARD_EN`.
- Derived `NODE_WIDTH = 1 + FIDX_W + FEATURE_WIDTH + 2*NODE_ADDR_WIDTH`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: node write strobe.
- `wr_addr` in `TREE_W+NODE_ADDR_WIDTH`: `{tree, node}`.
- `wr_data` in `NODE_WIDTH`: node word.
- `wr_drop` out 1: one-cycle pulse when a write is discarded.
- `in_valid` in 1, `in_ready` out 1: request handshake.
- `in_tree` in `TREE_W`: tree to walk.
- `in_features` in `NUM_FEATURES*FEATURE_WIDTH`: feature `i` at `[i*FEATURE_WIDTH +: FEATURE_WIDTH]`.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_class` out `CLASS_WIDTH`: leaf class.
- `out_err` out 1: depth-guard abort flag.
- `out_depth` out 8: nodes visited, leaf included, saturating at 255.

## Operation
- Node word, MSB to LSB: `is_leaf`, `feat_idx`, `threshold`, `left`, `right`. For a leaf, `out_class` is the low `CLASS_WIDTH` bits of the word and all other fields are ignored. The root is node 0 of each tree.
- Memory: `NUM_TREES << NODE_ADDR_WIDTH` words, uninitialised. Registered read with 1-cycle latency.
- Writes take effect only in IDLE. A `wr_en` in any other state is discarded and `wr_drop` pulses on the next cycle.
- FSM states: IDLE → FETCH → EVAL → FETCH/DONE; DONE → IDLE.
  - IDLE: `in_ready=1`. On `in_valid`, capture `in_tree` and `in_features`, set node=0 and depth=0, then go to FETCH.
  - FETCH: present `{tree, node}` to the memory; depth+1.
  - EVAL: the node word is valid.
    - Leaf: latch the class and go to DONE.
    - Otherwise: signed compare `feature[feat_idx] <= threshold`. True → node=`left`; false → node=`right`. Go to FETCH.
    - If `feat_idx >= NUM_FEATURES`, the feature value used is 0.
  - DONE: `out_valid=1`. Hold all outputs stable until `out_ready`, then go to IDLE. No new request is accepted in the DONE cycle.
- A child address that wraps is used modulo `2^NODE_ADDR_WIDTH` within the same tree. Walks never cross trees.

## Timing
- Reset values: `in_ready=0` during reset and 1 from the first cycle after it. `out_valid=0`, `out_class=0`, `out_err=0`, `out_depth=0`, `wr_drop=0`. FSM state is IDLE.
- Reset mid-walk aborts immediately. No result is produced. Memory contents are preserved.
- Latency from accept to `out_valid` is `2*D + 1` cycles, where D = nodes visited. A root leaf gives 3 cycles.
- Throughput is one request per `2*D + 2` cycles when `out_ready` is tied high.
- When `wr_en` and `in_valid` are both asserted in IDLE, the write commits and the request is accepted. The walk's first FETCH reads the new data.

## Configuration
- `DT_DEPTH_GUARD_EN` defined: in EVAL, if a non-leaf node is reached with depth == `MAX_DEPTH`, go to DONE with `out_err=1` and `out_class=0`.
- Not defined: there is no limit check and `out_err` is tied 0. A cyclic tree walks forever and only `rst` recovers it.

## Test plan
- Root leaf: write tree 0 node 0 = leaf class 5, request → `out_valid` 3 cycles after accept, `out_class=5`, `out_depth=1`, `out_err=0`.
- Three-level tree, tree 3: root `feat_idx`=2, threshold=-4.
  - Feature2=-4 → left leaf class 1.
  - Feature2=-3 → right leaf class 2.
  - Both results have `out_depth=2` and latency 5.
- Backpressure: hold `out_ready=0` for 10 cycles → `out_valid` and `out_class` stay stable and `in_ready=0`. Release → one transfer, then IDLE.
- Write during walk: `wr_en` while in EVAL → `wr_drop` pulses one cycle and a memory readback via a later walk shows the old word.
- Guard: with `DT_DEPTH_GUARD_EN` and `MAX_DEPTH=4`, node 0 has left=right=0 → result after 9 cycles with `out_err=1`, `out_class=0`, `out_depth=4`.
- Reset asserted mid-walk → the next cycle shows `out_valid=0`, and the next request returns the correct class.
